// File: rtl/cmac_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the CMAC TX AXI-Stream port
// between the adapter TX path (p0) and the hairpin loopback return (p1).
module cmac_tx_arbiter #(
    parameter int DATA_W = 512,
    parameter int KEEP_W = DATA_W / 8,
    parameter int CNT_W  = 32
) (
    input  logic              cmac_clk,
    input  logic              rstn,

    input  logic              s_axis_p0_tvalid,
    input  logic [DATA_W-1:0] s_axis_p0_tdata,
    input  logic [KEEP_W-1:0] s_axis_p0_tkeep,
    input  logic              s_axis_p0_tlast,
    input  logic              s_axis_p0_tuser_err,
    output logic              s_axis_p0_tready,

    input  logic              s_axis_p1_tvalid,
    input  logic [DATA_W-1:0] s_axis_p1_tdata,
    input  logic [KEEP_W-1:0] s_axis_p1_tkeep,
    input  logic              s_axis_p1_tlast,
    input  logic              s_axis_p1_tuser_err,
    output logic              s_axis_p1_tready,

    output logic              m_axis_cmac_tvalid,
    output logic [DATA_W-1:0] m_axis_cmac_tdata,
    output logic [KEEP_W-1:0] m_axis_cmac_tkeep,
    output logic              m_axis_cmac_tlast,
    output logic              m_axis_cmac_tuser_err,
    input  logic              m_axis_cmac_tready,

    output logic [CNT_W-1:0]  pkt_cnt_p0,
    output logic [CNT_W-1:0]  pkt_cnt_p1,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0]   cnt0_q, cnt0_d;
    logic [CNT_W-1:0]   cnt1_q, cnt1_d;

    // last_gnt resets to 1 so p0 wins the first tie after reset.
    always_ff @(posedge cmac_clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
        end
    end

    always_comb begin
        state_d               = state_q;
        last_gnt_d            = last_gnt_q;
        cnt0_d                = cnt0_q;
        cnt1_d                = cnt1_q;
        s_axis_p0_tready      = 1'b0;
        s_axis_p1_tready      = 1'b0;
        m_axis_cmac_tvalid    = 1'b0;
        m_axis_cmac_tdata     = '0;
        m_axis_cmac_tkeep     = '0;
        m_axis_cmac_tlast     = 1'b0;
        m_axis_cmac_tuser_err = 1'b0;

        case (state_q)
            IDLE: begin
                if (s_axis_p0_tvalid && s_axis_p1_tvalid)
                    state_d = last_gnt_q ? GNT0 : GNT1;
                else if (s_axis_p0_tvalid)
                    state_d = GNT0;
                else if (s_axis_p1_tvalid)
                    state_d = GNT1;
            end
            GNT0: begin
                m_axis_cmac_tvalid    = s_axis_p0_tvalid;
                m_axis_cmac_tdata     = s_axis_p0_tdata;
                m_axis_cmac_tkeep     = s_axis_p0_tkeep;
                m_axis_cmac_tlast     = s_axis_p0_tlast;
                m_axis_cmac_tuser_err = s_axis_p0_tuser_err;
                s_axis_p0_tready      = m_axis_cmac_tready;
                if (s_axis_p0_tvalid && m_axis_cmac_tready && s_axis_p0_tlast) begin
                    state_d    = IDLE;
                    last_gnt_d = 1'b0;
                    cnt0_d     = cnt0_q + CNT_W'(1);
                end
            end
            GNT1: begin
                m_axis_cmac_tvalid    = s_axis_p1_tvalid;
                m_axis_cmac_tdata     = s_axis_p1_tdata;
                m_axis_cmac_tkeep     = s_axis_p1_tkeep;
                m_axis_cmac_tlast     = s_axis_p1_tlast;
                m_axis_cmac_tuser_err = s_axis_p1_tuser_err;
                s_axis_p1_tready      = m_axis_cmac_tready;
                if (s_axis_p1_tvalid && m_axis_cmac_tready && s_axis_p1_tlast) begin
                    state_d    = IDLE;
                    last_gnt_d = 1'b1;
                    cnt1_d     = cnt1_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant      = {state_q == GNT1, state_q == GNT0};
    assign pkt_cnt_p0 = cnt0_q;
    assign pkt_cnt_p1 = cnt1_q;

endmodule

// File: tb/tb_cmac_tx_arbiter.sv
// Directed bench for cmac_tx_arbiter: two scripted AXI-S sources, checks at negedge.
module tb_cmac_tx_arbiter;

    localparam int DW = 64;
    localparam int KW = 8;
    localparam int CW = 4;

    logic          cmac_clk;
    logic          rstn;
    logic          s_axis_p0_tvalid, s_axis_p0_tlast, s_axis_p0_tuser_err, s_axis_p0_tready;
    logic [DW-1:0] s_axis_p0_tdata;
    logic [KW-1:0] s_axis_p0_tkeep;
    logic          s_axis_p1_tvalid, s_axis_p1_tlast, s_axis_p1_tuser_err, s_axis_p1_tready;
    logic [DW-1:0] s_axis_p1_tdata;
    logic [KW-1:0] s_axis_p1_tkeep;
    logic          m_axis_cmac_tvalid, m_axis_cmac_tlast, m_axis_cmac_tuser_err, m_axis_cmac_tready;
    logic [DW-1:0] m_axis_cmac_tdata;
    logic [KW-1:0] m_axis_cmac_tkeep;
    logic [CW-1:0] pkt_cnt_p0, pkt_cnt_p1;
    logic [1:0]    grant;

    int checks = 0;
    int errors = 0;

    // Scripted source state: packets sent, beat within packet, packet length,
    // packet count, and which packet index carries tuser_err on its last beat.
    int pkt [2];
    int beat[2];
    int len [2];
    int npk [2];
    int errp[2];

    cmac_tx_arbiter #(.DATA_W(DW), .KEEP_W(KW), .CNT_W(CW)) dut (
        .cmac_clk              (cmac_clk),
        .rstn                  (rstn),
        .s_axis_p0_tvalid      (s_axis_p0_tvalid),
        .s_axis_p0_tdata       (s_axis_p0_tdata),
        .s_axis_p0_tkeep       (s_axis_p0_tkeep),
        .s_axis_p0_tlast       (s_axis_p0_tlast),
        .s_axis_p0_tuser_err   (s_axis_p0_tuser_err),
        .s_axis_p0_tready      (s_axis_p0_tready),
        .s_axis_p1_tvalid      (s_axis_p1_tvalid),
        .s_axis_p1_tdata       (s_axis_p1_tdata),
        .s_axis_p1_tkeep       (s_axis_p1_tkeep),
        .s_axis_p1_tlast       (s_axis_p1_tlast),
        .s_axis_p1_tuser_err   (s_axis_p1_tuser_err),
        .s_axis_p1_tready      (s_axis_p1_tready),
        .m_axis_cmac_tvalid    (m_axis_cmac_tvalid),
        .m_axis_cmac_tdata     (m_axis_cmac_tdata),
        .m_axis_cmac_tkeep     (m_axis_cmac_tkeep),
        .m_axis_cmac_tlast     (m_axis_cmac_tlast),
        .m_axis_cmac_tuser_err (m_axis_cmac_tuser_err),
        .m_axis_cmac_tready    (m_axis_cmac_tready),
        .pkt_cnt_p0            (pkt_cnt_p0),
        .pkt_cnt_p1            (pkt_cnt_p1),
        .grant                 (grant)
    );

    initial cmac_clk = 1'b0;
    always #5 cmac_clk = ~cmac_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running exp finished");
        $fatal(1);
    end

    function automatic logic [DW-1:0] mk_data(int p, int k, int b);
        return 64'hA5A5_0000_0000_0000 | DW'(p * 256 + k * 16 + b);
    endfunction

    function automatic logic [KW-1:0] mk_keep(logic last);
        return last ? 8'h0F : 8'hFF;
    endfunction

    task automatic drive();
        s_axis_p0_tvalid    = pkt[0] < npk[0];
        s_axis_p0_tlast     = beat[0] == len[0] - 1;
        s_axis_p0_tdata     = mk_data(0, pkt[0], beat[0]);
        s_axis_p0_tkeep     = mk_keep(s_axis_p0_tlast);
        s_axis_p0_tuser_err = s_axis_p0_tlast && pkt[0] == errp[0];
        s_axis_p1_tvalid    = pkt[1] < npk[1];
        s_axis_p1_tlast     = beat[1] == len[1] - 1;
        s_axis_p1_tdata     = mk_data(1, pkt[1], beat[1]);
        s_axis_p1_tkeep     = mk_keep(s_axis_p1_tlast);
        s_axis_p1_tuser_err = s_axis_p1_tlast && pkt[1] == errp[1];
    endtask

    task automatic src_clear();
        for (int p = 0; p < 2; p++) begin
            pkt[p] = 0; beat[p] = 0; len[p] = 1; npk[p] = 0; errp[p] = -1;
        end
        drive();
    endtask

    // Advance one clock; sources step their beat on a handshake.
    task automatic advance();
        logic f0, f1;
        f0 = s_axis_p0_tvalid & s_axis_p0_tready;
        f1 = s_axis_p1_tvalid & s_axis_p1_tready;
        @(posedge cmac_clk);
        #1;
        if (f0) begin
            if (beat[0] == len[0] - 1) begin beat[0] = 0; pkt[0]++; end
            else beat[0]++;
        end
        if (f1) begin
            if (beat[1] == len[1] - 1) begin beat[1] = 0; pkt[1]++; end
            else beat[1]++;
        end
        drive();
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        src_clear();
        m_axis_cmac_tready = 1'b1;
        @(posedge cmac_clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        src_clear();
        npk[0] = 1; npk[1] = 1;
        m_axis_cmac_tready = 1'b1;
        drive();
        #3;
        checks++;
        if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b exp 00", grant); end
        checks++;
        if ({m_axis_cmac_tvalid, s_axis_p0_tready, s_axis_p1_tready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_handshake: got %b exp 000",
                     {m_axis_cmac_tvalid, s_axis_p0_tready, s_axis_p1_tready});
        end
        checks++;
        if (pkt_cnt_p0 !== 4'd0 || pkt_cnt_p1 !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d/%0d exp 0/0", pkt_cnt_p0, pkt_cnt_p1);
        end
        @(posedge cmac_clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_single_p0();
        logic [1:0] g_exp[5] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
        apply_reset();
        len[0] = 3; npk[0] = 1;
        drive();
        for (int c = 0; c < 5; c++) begin
            @(negedge cmac_clk);
            checks++;
            if (grant !== g_exp[c]) begin
                errors++; $display("FAIL p0_grant c%0d: got %b exp %b", c, grant, g_exp[c]);
            end
            checks++;
            if (m_axis_cmac_tvalid !== (c >= 1 && c <= 3)) begin
                errors++; $display("FAIL p0_mvalid c%0d: got %b", c, m_axis_cmac_tvalid);
            end
            if (c >= 1 && c <= 3) begin
                checks++;
                if (m_axis_cmac_tdata !== mk_data(0, 0, c - 1) ||
                    m_axis_cmac_tkeep !== mk_keep(c == 3) ||
                    m_axis_cmac_tlast !== (c == 3) || s_axis_p0_tready !== 1'b1) begin
                    errors++;
                    $display("FAIL p0_beat c%0d: got %h/%h/%b/%b exp %h/%h/%b/1", c,
                             m_axis_cmac_tdata, m_axis_cmac_tkeep, m_axis_cmac_tlast,
                             s_axis_p0_tready, mk_data(0, 0, c - 1), mk_keep(c == 3), c == 3);
                end
            end
            if (c == 4) begin
                checks++;
                if (pkt_cnt_p0 !== 4'd1) begin
                    errors++; $display("FAIL p0_cnt: got %0d exp 1", pkt_cnt_p0);
                end
            end
            advance();
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] g_exp[13] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
                                  2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        logic [DW-1:0] d_exp[13];
        d_exp = '{64'h0, mk_data(0, 0, 0), mk_data(0, 0, 1), 64'h0,
                  mk_data(1, 0, 0), mk_data(1, 0, 1), 64'h0,
                  mk_data(0, 1, 0), mk_data(0, 1, 1), 64'h0,
                  mk_data(1, 1, 0), mk_data(1, 1, 1), 64'h0};
        apply_reset();
        len[0] = 2; npk[0] = 2; len[1] = 2; npk[1] = 2;
        drive();
        for (int c = 0; c < 13; c++) begin
            @(negedge cmac_clk);
            checks++;
            if (grant !== g_exp[c]) begin
                errors++; $display("FAIL rr_grant c%0d: got %b exp %b", c, grant, g_exp[c]);
            end
            if (g_exp[c] != 2'b00) begin
                checks++;
                if (m_axis_cmac_tdata !== d_exp[c] || m_axis_cmac_tvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_data c%0d: got %h exp %h", c, m_axis_cmac_tdata, d_exp[c]);
                end
            end
            if (c == 3) begin
                checks++;
                if (pkt_cnt_p0 !== 4'd1 || pkt_cnt_p1 !== 4'd0) begin
                    errors++; $display("FAIL rr_cnt_mid: got %0d/%0d exp 1/0", pkt_cnt_p0, pkt_cnt_p1);
                end
            end
            if (c == 12) begin
                checks++;
                if (pkt_cnt_p0 !== 4'd2 || pkt_cnt_p1 !== 4'd2) begin
                    errors++; $display("FAIL rr_cnt_end: got %0d/%0d exp 2/2", pkt_cnt_p0, pkt_cnt_p1);
                end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        logic       rdy[8]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [1:0] g_exp[8] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
        int         b_exp[8] = '{0, 0, 1, 1, 1, 2, 0, 0};
        apply_reset();
        len[1] = 3; npk[1] = 1;
        drive();
        for (int c = 0; c < 8; c++) begin
            if (c == 1) begin len[0] = 1; npk[0] = 1; end
            m_axis_cmac_tready = rdy[c];
            drive();
            @(negedge cmac_clk);
            checks++;
            if (grant !== g_exp[c]) begin
                errors++; $display("FAIL bp_grant c%0d: got %b exp %b", c, grant, g_exp[c]);
            end
            if (c >= 1 && c <= 5) begin
                checks++;
                if (m_axis_cmac_tdata !== mk_data(1, 0, b_exp[c]) || m_axis_cmac_tvalid !== 1'b1 ||
                    s_axis_p0_tready !== 1'b0 || s_axis_p1_tready !== rdy[c]) begin
                    errors++;
                    $display("FAIL bp_beat c%0d: got %h rdy %b/%b exp %h rdy 0/%b", c,
                             m_axis_cmac_tdata, s_axis_p0_tready, s_axis_p1_tready,
                             mk_data(1, 0, b_exp[c]), rdy[c]);
                end
            end
            if (c == 7) begin
                checks++;
                if (m_axis_cmac_tdata !== mk_data(0, 0, 0) || pkt_cnt_p1 !== 4'd1) begin
                    errors++;
                    $display("FAIL bp_after: got %h cnt %0d exp %h cnt 1",
                             m_axis_cmac_tdata, pkt_cnt_p1, mk_data(0, 0, 0));
                end
            end
            advance();
        end
        m_axis_cmac_tready = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic v_exp[7]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int   cnt_exp[7] = '{0, 0, 1, 1, 2, 2, 3};
        apply_reset();
        len[1] = 1; npk[1] = 3;
        drive();
        for (int c = 0; c < 7; c++) begin
            @(negedge cmac_clk);
            checks++;
            if (m_axis_cmac_tvalid !== v_exp[c]) begin
                errors++; $display("FAIL b2b_mvalid c%0d: got %b exp %b", c, m_axis_cmac_tvalid, v_exp[c]);
            end
            checks++;
            if (pkt_cnt_p1 !== CW'(cnt_exp[c])) begin
                errors++; $display("FAIL b2b_cnt c%0d: got %0d exp %0d", c, pkt_cnt_p1, cnt_exp[c]);
            end
            advance();
        end
    endtask

    // Runs straight after test_back_to_back so pkt_cnt_p1 starts non-zero.
    task automatic test_reset_mid_packet();
        logic [1:0] g_exp[4] = '{2'b00, 2'b01, 2'b00, 2'b10};
        src_clear();
        len[0] = 4; npk[0] = 1;
        drive();
        for (int c = 0; c < 3; c++) begin
            @(negedge cmac_clk);
            if (c == 2) begin
                checks++;
                if (m_axis_cmac_tdata !== mk_data(0, 0, 1) || m_axis_cmac_tvalid !== 1'b1) begin
                    errors++; $display("FAIL rst_mid_pre: got %h exp %h", m_axis_cmac_tdata, mk_data(0, 0, 1));
                end
            end else advance();
        end
        #1;
        rstn = 1'b0;
        #1;
        checks++;
        if ({m_axis_cmac_tvalid, s_axis_p0_tready, s_axis_p1_tready, grant} !== 5'b00000) begin
            errors++;
            $display("FAIL rst_mid_drop: got %b exp 00000",
                     {m_axis_cmac_tvalid, s_axis_p0_tready, s_axis_p1_tready, grant});
        end
        checks++;
        if (pkt_cnt_p0 !== 4'd0 || pkt_cnt_p1 !== 4'd0) begin
            errors++; $display("FAIL rst_mid_cnt: got %0d/%0d exp 0/0", pkt_cnt_p0, pkt_cnt_p1);
        end
        src_clear();
        @(posedge cmac_clk);
        #1;
        rstn = 1'b1;
        len[0] = 1; npk[0] = 1; len[1] = 1; npk[1] = 1;
        drive();
        for (int c = 0; c < 4; c++) begin
            @(negedge cmac_clk);
            checks++;
            if (grant !== g_exp[c]) begin
                errors++; $display("FAIL rst_mid_tie c%0d: got %b exp %b", c, grant, g_exp[c]);
            end
            advance();
        end
    endtask

    task automatic test_wrap_err();
        apply_reset();
        len[0] = 1; npk[0] = 16; errp[0] = 15;
        drive();
        for (int c = 0; c < 33; c++) begin
            @(negedge cmac_clk);
            if (c == 1) begin
                checks++;
                if (m_axis_cmac_tuser_err !== 1'b0 || m_axis_cmac_tvalid !== 1'b1) begin
                    errors++; $display("FAIL wrap_noerr: got err %b vld %b exp 0 1",
                                       m_axis_cmac_tuser_err, m_axis_cmac_tvalid);
                end
            end
            if (c == 30) begin
                checks++;
                if (pkt_cnt_p0 !== 4'd15) begin
                    errors++; $display("FAIL wrap_pre: got %0d exp 15", pkt_cnt_p0);
                end
            end
            if (c == 31) begin
                checks++;
                if (m_axis_cmac_tuser_err !== 1'b1 || m_axis_cmac_tlast !== 1'b1 ||
                    m_axis_cmac_tdata !== mk_data(0, 15, 0)) begin
                    errors++; $display("FAIL wrap_err_pass: got err %b last %b data %h exp 1 1 %h",
                                       m_axis_cmac_tuser_err, m_axis_cmac_tlast,
                                       m_axis_cmac_tdata, mk_data(0, 15, 0));
                end
            end
            if (c == 32) begin
                checks++;
                if (pkt_cnt_p0 !== 4'd0 || grant !== 2'b00) begin
                    errors++; $display("FAIL wrap_cnt: got %0d grant %b exp 0 00", pkt_cnt_p0, grant);
                end
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_single_p0();
        test_round_robin();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_packet();
        test_wrap_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
